// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: LSU operations, writeback selects,
// FSM states and exception bit positions.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LB, LH, LW, LBU, LHU, SB, SH, SW
    } load_store_func_code;

    typedef enum logic [1:0] {
        WB_ALU, WB_LOAD, WB_PC, WB_UIMMD
    } write_back_mux_selector;

    typedef enum logic [1:0] {
        IDLE, WAIT_GNT, WAIT_RVALID
    } mem_fsm_state_e;

    localparam int EXC_MISALIGNED = 0;
    localparam int EXC_BUS_ERR    = 1;

    function automatic logic is_store(input load_store_func_code op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_misaligned(input load_store_func_code op,
                                           input logic [1:0] offset);
        case (op)
            LH, LHU, SH: return offset[0];
            LW, SW:      return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  load_store_func_code op_i,
    input  logic [1:0]          offset_i,
    input  logic [31:0]         store_data_i,
    input  logic [31:0]         rdata_i,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         load_data_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        case (op_i)
            SB: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SH: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            LB:      load_data_o = {{24{lane[7]}}, lane[7:0]};
            LBU:     load_data_o = {24'h000000, lane[7:0]};
            LH:      load_data_o = {{16{lane[15]}}, lane[15:0]};
            LHU:     load_data_o = {16'h0000, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid port, stalls the
// front of the pipeline while an access is outstanding, and fills MEM-WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   lsu_enable_ip,
    input  load_store_func_code    lsu_operator_ip,
    input  logic [31:0]            mem_wdata_ip,
    input  logic [31:0]            alu_result_ip,
    input  logic                   alu_valid_ip,
    input  write_back_mux_selector wb_mux_ip,
    input  logic [4:0]             write_reg_addr_ip,
    input  logic [31:0]            pc_addr_ip,
    input  logic [31:0]            uimmd_ip,
    output logic                   data_req_op,
    output logic [31:0]            data_addr_op,
    output logic                   data_we_op,
    output logic [3:0]             data_be_op,
    output logic [31:0]            data_wdata_op,
    input  logic                   data_gnt_ip,
    input  logic                   data_rvalid_ip,
    input  logic [31:0]            data_rdata_ip,
    output logic                   stall_op,
    output logic [1:0]             exc_op,
    output logic                   wb_valid_op,
    output logic [31:0]            wb_alu_result_op,
    output logic [31:0]            wb_load_data_op,
    output write_back_mux_selector wb_mux_op,
    output logic [4:0]             wb_write_reg_addr_op,
    output logic [31:0]            wb_pc_addr_op,
    output logic [31:0]            wb_uimmd_op
);

    mem_fsm_state_e         state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    load_store_func_code    acc_op_q;
    logic [31:0]            acc_addr_q, acc_wdata_q, acc_pc_q, acc_uimmd_q;
    logic [4:0]             acc_rd_q;
    write_back_mux_selector acc_wb_mux_q;
    logic [1:0]             exc_q;

    logic                   wb_valid_q;
    logic [31:0]            wb_alu_result_q, wb_load_data_q, wb_pc_addr_q, wb_uimmd_q;
    logic [4:0]             wb_write_reg_addr_q;
    write_back_mux_selector wb_mux_q;

    logic                   in_idle, cur_store, cur_misaligned, timeout;
    load_store_func_code    cur_op;
    logic [31:0]            cur_addr, cur_wdata;
    logic                   req, stall, wb_valid_d, load_done, misalign_exc, bus_err_exc;
    logic [3:0]             align_be;
    logic [31:0]            align_wdata, align_load;

    // In IDLE the access is taken straight from EX-MEM; afterwards from the latched copy.
    assign in_idle        = (state_q == IDLE);
    assign cur_op         = in_idle ? lsu_operator_ip : acc_op_q;
    assign cur_addr       = in_idle ? alu_result_ip : acc_addr_q;
    assign cur_wdata      = in_idle ? mem_wdata_ip : acc_wdata_q;
    assign cur_store      = is_store(cur_op);
    assign cur_misaligned = is_misaligned(cur_op, cur_addr[1:0]);
    assign timeout        = !in_idle && (wait_cnt_q == 8'(MAX_WAIT - 1));

    mem_stage_lsu_align u_align (
        .op_i         (cur_op),
        .offset_i     (cur_addr[1:0]),
        .store_data_i (cur_wdata),
        .rdata_i      (data_rdata_ip),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = 8'd0;
        req          = 1'b0;
        stall        = 1'b0;
        wb_valid_d   = 1'b0;
        load_done    = 1'b0;
        misalign_exc = 1'b0;
        bus_err_exc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_enable_ip && alu_valid_ip) begin
                    if (cur_misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (data_gnt_ip && cur_store) begin
                            wb_valid_d = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = data_gnt_ip ? WAIT_RVALID : WAIT_GNT;
                        end
                    end
                end else begin
                    wb_valid_d = alu_valid_ip;
                end
            end
            WAIT_GNT: begin
                if (timeout) begin
                    bus_err_exc = 1'b1;
                    state_d     = IDLE;
                end else begin
                    req = 1'b1;
                    if (data_gnt_ip && cur_store) begin
                        wb_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else if (data_gnt_ip) begin
                        stall   = 1'b1;
                        state_d = WAIT_RVALID;
                    end else begin
                        stall      = 1'b1;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_ip) begin
                    wb_valid_d = 1'b1;
                    load_done  = 1'b1;
                    state_d    = IDLE;
                end else if (timeout) begin
                    bus_err_exc = 1'b1;
                    state_d     = IDLE;
                end else begin
                    stall      = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            exc_q        <= 2'b00;
            acc_op_q     <= LB;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            acc_rd_q     <= '0;
            acc_wb_mux_q <= WB_ALU;
            acc_pc_q     <= '0;
            acc_uimmd_q  <= '0;
        end else begin
            state_q                <= state_d;
            wait_cnt_q             <= wait_cnt_d;
            exc_q[EXC_MISALIGNED]  <= misalign_exc;
            exc_q[EXC_BUS_ERR]     <= bus_err_exc;
            if (in_idle) begin
                acc_op_q     <= lsu_operator_ip;
                acc_addr_q   <= alu_result_ip;
                acc_wdata_q  <= mem_wdata_ip;
                acc_rd_q     <= write_reg_addr_ip;
                acc_wb_mux_q <= wb_mux_ip;
                acc_pc_q     <= pc_addr_ip;
                acc_uimmd_q  <= uimmd_ip;
            end
        end
    end

    // A stalled cycle always writes a bubble so WB never retires an entry twice.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q          <= 1'b0;
            wb_alu_result_q     <= '0;
            wb_load_data_q      <= '0;
            wb_mux_q            <= WB_ALU;
            wb_write_reg_addr_q <= '0;
            wb_pc_addr_q        <= '0;
            wb_uimmd_q          <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (!stall) begin
                wb_alu_result_q     <= in_idle ? alu_result_ip : acc_addr_q;
                wb_load_data_q      <= load_done ? align_load : 32'h0;
                wb_mux_q            <= in_idle ? wb_mux_ip : acc_wb_mux_q;
                wb_write_reg_addr_q <= in_idle ? write_reg_addr_ip : acc_rd_q;
                wb_pc_addr_q        <= in_idle ? pc_addr_ip : acc_pc_q;
                wb_uimmd_q          <= in_idle ? uimmd_ip : acc_uimmd_q;
            end
        end
    end

    assign data_req_op          = req;
    assign data_addr_op         = req ? {cur_addr[31:2], 2'b00} : 32'h0;
    assign data_we_op           = req && cur_store;
    assign data_be_op           = req ? align_be : 4'b0000;
    assign data_wdata_op        = (req && cur_store) ? align_wdata : 32'h0;
    assign stall_op             = stall;
    assign exc_op               = exc_q;
    assign wb_valid_op          = wb_valid_q;
    assign wb_alu_result_op     = wb_alu_result_q;
    assign wb_load_data_op      = wb_load_data_q;
    assign wb_mux_op            = wb_mux_q;
    assign wb_write_reg_addr_op = wb_write_reg_addr_q;
    assign wb_pc_addr_op        = wb_pc_addr_q;
    assign wb_uimmd_op          = wb_uimmd_q;

endmodule
